// File: rtl/weprom_ser.sv
// Serial EEPROM write framer: collects an LSB-first address/data word pair over cs,
// then shifts {address, data, parity} out MSB-first on sda/sda_clk.
module weprom_ser #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int PARITY_EN = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic address,
  input  logic data,
  output logic ack,
  output logic out_valid,
  output logic sda,
  output logic sda_clk,
  output logic busy,
  output logic err
);

  localparam int L     = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int F     = ADDR_W + DATA_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BIT_W = $clog2(F);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_PAUSE, S_ACK, S_SHIFT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [GAP_W-1:0]   gap_q, gap_next;
  logic [DIV_W-1:0]   div_q;
  logic [BIT_W-1:0]   bit_q;
  logic [ADDR_W-1:0]  addr_sr;
  logic [DATA_W-1:0]  data_sr;
  logic [F-1:0]       frame_sr, frame_d;
  logic               err_q;
  logic               collecting, in_gap, sample, last_bit, timeout_hit, bit_end, frame_end;

  generate
    if (PARITY_EN != 0) begin : g_parity
      assign frame_d = {addr_sr, data_sr, ^{addr_sr, data_sr}};
    end else begin : g_no_parity
      assign frame_d = {addr_sr, data_sr};
    end
  endgenerate

  assign collecting  = (state_q == S_IDLE) || (state_q == S_COLLECT) || (state_q == S_PAUSE);
  assign in_gap      = ((state_q == S_COLLECT) || (state_q == S_PAUSE)) && !cs;
  assign sample      = collecting && cs;
  assign last_bit    = (count_q == CNT_W'(L - 1));
  // The first low cycle out of COLLECT counts as gap cycle 1.
  assign gap_next    = (state_q == S_PAUSE) ? gap_q + GAP_W'(1) : GAP_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && in_gap && (gap_next == GAP_W'(TIMEOUT));
  assign bit_end     = (div_q == DIV_W'(2 * CLK_DIV - 1));
  assign frame_end   = bit_end && (bit_q == BIT_W'(F - 1));

  // NOTE: synchronous reset only; every register sits inside the rst branch, shift registers included.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_COLLECT, S_PAUSE: begin
        if (cs)                     state_d = last_bit ? S_ACK : S_COLLECT;
        else if (timeout_hit)       state_d = S_IDLE;
        else if (state_q != S_IDLE) state_d = S_PAUSE;
      end
      S_ACK:   state_d = S_SHIFT;
      S_SHIFT: if (frame_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack       = (state_q == S_ACK);
    out_valid = (state_q == S_SHIFT);
    busy      = (state_q != S_IDLE) && (state_q != S_PAUSE);
    sda       = (state_q == S_SHIFT) ? frame_sr[F-1] : 1'b0;
    sda_clk   = (state_q == S_SHIFT) && (div_q >= DIV_W'(CLK_DIV));
    err       = err_q;
  end

  // NOTE: all state below uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      gap_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      frame_sr <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit;

      if (sample) begin
        for (int i = 0; i < ADDR_W; i++)
          if (count_q == CNT_W'(i)) addr_sr[i] <= address;
        for (int i = 0; i < DATA_W; i++)
          if (count_q == CNT_W'(i)) data_sr[i] <= data;
        count_q <= last_bit ? '0 : count_q + CNT_W'(1);
      end else if (timeout_hit) begin
        count_q <= '0;
      end

      if (in_gap) gap_q <= gap_next;

      if (state_q == S_ACK) begin
        frame_sr <= frame_d;
        div_q    <= '0;
        bit_q    <= '0;
      end else if (state_q == S_SHIFT) begin
        if (bit_end) begin
          div_q    <= '0;
          bit_q    <= bit_q + BIT_W'(1);
          frame_sr <= frame_sr << 1;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_weprom_ser.sv
// Directed bench for weprom_ser: default 8/8 instance plus a 4/12, CLK_DIV=1, no-parity instance.
module tb_weprom_ser;

  logic clk = 1'b0;
  logic rst;
  logic cs_a, addr_a, data_a, ack_a, ov_a, sda_a, sclk_a, busy_a, err_a;
  logic cs_b, addr_b, data_b, ack_b, ov_b, sda_b, sclk_b, busy_b, err_b;
  logic sel;
  logic mon_ack, mon_ov, mon_sda, mon_sclk, mon_busy, mon_err;
  int   n_vec = 0, n_miss = 0;
  int   ack_cnt = 0, err_cnt = 0;

  always #5 clk = ~clk;

  weprom_ser dut_a (
    .clk(clk), .rst(rst), .cs(cs_a), .address(addr_a), .data(data_a),
    .ack(ack_a), .out_valid(ov_a), .sda(sda_a), .sda_clk(sclk_a), .busy(busy_a), .err(err_a)
  );

  weprom_ser #(.ADDR_W(4), .DATA_W(12), .CLK_DIV(1), .PARITY_EN(0), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .cs(cs_b), .address(addr_b), .data(data_b),
    .ack(ack_b), .out_valid(ov_b), .sda(sda_b), .sda_clk(sclk_b), .busy(busy_b), .err(err_b)
  );

  assign mon_ack  = sel ? ack_b  : ack_a;
  assign mon_ov   = sel ? ov_b   : ov_a;
  assign mon_sda  = sel ? sda_b  : sda_a;
  assign mon_sclk = sel ? sclk_b : sclk_a;
  assign mon_busy = sel ? busy_b : busy_a;
  assign mon_err  = sel ? err_b  : err_a;

  always @(negedge clk) begin
    if (mon_ack) ack_cnt++;
    if (mon_err) err_cnt++;
  end

  typedef struct {
    string       name;
    logic        sel;
    logic [15:0] addr;
    logic [15:0] data;
    int          nbits;
    int          gap_at;
    int          gap_len;
    logic        toggle;
    logic [31:0] exp;
    int          fbits;
    int          div;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic c, input logic a, input logic d);
    if (sel) begin cs_b = c; addr_b = a; data_b = d; end
    else     begin cs_a = c; addr_a = a; data_a = d; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [15:0] a, input logic [15:0] d, input int from, input int to);
    for (int i = from; i < to; i++) begin
      set_in(1'b1, a[i], d[i]);
      tick();
    end
    set_in(1'b0, 1'b0, 1'b0);
  endtask

  // Entered in the ACK cycle; returns in the first cycle after SHIFT.
  task automatic check_frame(input logic [31:0] exp, input int fbits, input int div,
                             input logic toggle, input string name);
    logic [31:0] got;
    int          bad;
    logic        bitval;
    got = '0; bad = 0; bitval = 1'b0;
    check({name, " ack"}, 32'(mon_ack), 32'd1);
    tick();
    for (int b = 0; b < fbits; b++) begin
      for (int c = 0; c < 2 * div; c++) begin
        if (c == 0) bitval = mon_sda;
        else if (mon_sda !== bitval) bad++;
        if (mon_ov !== 1'b1 || mon_busy !== 1'b1 || mon_ack !== 1'b0 || mon_err !== 1'b0) bad++;
        if (mon_sclk !== (c >= div)) bad++;
        if (toggle) begin
          if (b == fbits - 1 && c == 2 * div - 1) set_in(1'b0, 1'b0, 1'b0);
          else set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        tick();
      end
      got = {got[30:0], bitval};
    end
    check({name, " frame"}, got, exp);
    check({name, " waveform"}, 32'(bad), 32'd0);
    check({name, " idle after"}, 32'({mon_ov, mon_sda, mon_sclk, mon_busy, mon_ack}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int e0, k0;
    sel = v.sel;
    set_in(1'b0, 1'b0, 1'b0);
    e0 = err_cnt;
    k0 = ack_cnt;
    if (v.gap_at > 0) begin
      drive_bits(v.addr, v.data, 0, v.gap_at);
      repeat (v.gap_len) tick();
      drive_bits(v.addr, v.data, v.gap_at, v.nbits);
    end else begin
      drive_bits(v.addr, v.data, 0, v.nbits);
    end
    check_frame(v.exp, v.fbits, v.div, v.toggle, v.name);
    check({v.name, " err count"}, 32'(err_cnt - e0), 32'd0);
    check({v.name, " ack count"}, 32'(ack_cnt - k0), 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int e0, k0;
    vecs[0] = '{"basic",      1'b0, 16'h00A5, 16'h00B2, 8,  0, 0,  1'b0, 32'({8'hA5, 8'hB2, 1'b0}), 17, 2};
    vecs[1] = '{"pause",      1'b0, 16'h00A5, 16'h00B2, 8,  5, 10, 1'b0, 32'({8'hA5, 8'hB2, 1'b0}), 17, 2};
    vecs[2] = '{"gap_tmo_m1", 1'b0, 16'h0080, 16'h0000, 8,  7, 15, 1'b0, 32'({8'h80, 8'h00, 1'b1}), 17, 2};
    vecs[3] = '{"masking",    1'b0, 16'h0001, 16'h00FF, 8,  0, 0,  1'b1, 32'({8'h01, 8'hFF, 1'b1}), 17, 2};
    vecs[4] = '{"sweep",      1'b1, 16'h0FF9, 16'h0A5C, 12, 0, 0,  1'b0, 32'({4'h9, 12'hA5C}),      16, 1};

    sel = 1'b0;
    rst = 1'b1;
    cs_a = 0; addr_a = 0; data_a = 0;
    cs_b = 0; addr_b = 0; data_b = 0;
    tick();
    tick();
    check("reset outputs a", 32'({ack_a, ov_a, sda_a, sclk_a, busy_a, err_a}), 32'd0);
    check("reset outputs b", 32'({ack_b, ov_b, sda_b, sclk_b, busy_b, err_b}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Timeout: 5 bits then 16 low cycles.
    sel = 1'b0;
    e0 = err_cnt;
    k0 = ack_cnt;
    drive_bits(16'h00A5, 16'h00B2, 0, 5);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) check("timeout no early err", 32'(err_a), 32'd0);
      if (k == 16) check("timeout err", 32'({err_a, busy_a}), 32'b10);
    end
    tick();
    check("timeout err one cycle", 32'(err_a), 32'd0);
    check("timeout err count", 32'(err_cnt - e0), 32'd1);
    check("timeout no ack", 32'(ack_cnt - k0), 32'd0);
    run_vec('{"after_timeout", 1'b0, 16'h000F, 16'h000F, 8, 0, 0, 1'b0, 32'({8'h0F, 8'h0F, 1'b0}), 17, 2});

    // Reset at frame bit 6.
    drive_bits(16'h00A5, 16'h00B2, 0, 8);
    tick();
    repeat (24) tick();
    check("pre-reset shifting", 32'(ov_a), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset mid-shift", 32'({ack_a, ov_a, sda_a, sclk_a, busy_a, err_a}), 32'd0);
    repeat (8) tick();
    check("no resume after reset", 32'({ov_a, busy_a}), 32'd0);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/weprom_ser.md
Name: weprom_ser

Overview:
Parametrised serial-to-serial EEPROM write framer.
- Collects an address word and a data word, one bit of each per clock, while cs is high.
- Tolerates cs gaps (pause/resume) up to a programmable timeout.
- Acknowledges a complete word pair, then serialises {address, data, optional parity} MSB-first on sda/sda_clk toward the EEPROM pin interface.
- Generalises the fixed 8+8-bit framer: independent widths, programmable serial clock rate, parity, gap timeout and error reporting.

Parameters:
ADDR_W, 8, address width in bits (>=1)
DATA_W, 8, data width in bits (>=1)
CLK_DIV, 2, clk cycles per sda_clk half-period (>=1)
PARITY_EN, 1, 1 = append even-parity bit over address and data
TIMEOUT, 16, cs-low gap (clk cycles) that aborts a partial collection; 0 = never abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cs  in  1  collect enable; bit sampled on every clk with cs=1 while collecting
address  in  1  serial address bit, LSB first
data  in  1  serial data bit, LSB first
ack  out  1  one-cycle pulse: full word pair captured
out_valid  out  1  high while a frame is being shifted out
sda  out  1  serial frame data
sda_clk  out  1  serial frame clock
busy  out  1  high in every state except IDLE/PAUSE
err  out  1  one-cycle pulse: partial collection discarded on timeout

Behaviour:
- L = max(ADDR_W, DATA_W) collection bits; F = ADDR_W + DATA_W + PARITY_EN frame bits.
- Bit i of each input goes to register bit i; address bits at i >= ADDR_W and data bits at i >= DATA_W are ignored.
- Reset: state IDLE, counters and shift registers 0; ack, out_valid, sda, sda_clk, busy, err all 0 on the edge after rst=1.
  - Reset overrides any state, including mid-SHIFT. No partial frame resumes after reset.
- IDLE: on cs=1, sample bit 0, count=1, go to COLLECT (or straight to ACK if L=1).
- COLLECT:
  - cs=1: sample bit[count], count++. Once L bits are held, go to ACK.
  - cs=0: go to PAUSE, gap counter = 1.
- PAUSE:
  - cs=1: sample bit[count] that same cycle, return to COLLECT (or ACK if that was bit L-1).
  - cs=0: gap counter++. When it reaches TIMEOUT (TIMEOUT != 0), pulse err for 1 cycle, clear count, go to IDLE.
- ACK: ack=1 for exactly one cycle, starting the cycle after the L-th bit is sampled. Latch frame {address[ADDR_W-1:0], data[DATA_W-1:0], parity}. Go to SHIFT.
- Parity: XOR of all ADDR_W + DATA_W bits, so the count of ones including parity is even.
- SHIFT:
  - Each frame bit occupies 2*CLK_DIV clk cycles: sda_clk=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - sda changes only at the start of the low phase and is stable while sda_clk=1.
  - The first frame bit (address MSB) is driven in the first SHIFT cycle. out_valid=1 for all F*2*CLK_DIV SHIFT cycles.
  - After the last high phase: sda=0, sda_clk=0, out_valid=0, return to IDLE.
- cs, address and data are ignored in ACK and SHIFT; bits presented then are dropped.
  - cs held high across the return to IDLE starts a new collection on the first IDLE cycle.
- Simultaneous events:
  - The L-th bit sampled from PAUSE goes to ACK, with no err, even if the gap counter was at TIMEOUT-1.
  - err and ack are never asserted in the same cycle.

Test Plan:
Defaults (8/8, CLK_DIV=2, PARITY_EN=1, TIMEOUT=16) unless stated.
- Basic frame: cs=1 for 8 cycles, address LSB-first 1,0,1,0,0,1,0,1 (0xA5), data 0,1,0,0,1,1,0,1 (0xB2) -> ack one cycle after the 8th bit; sda shows 1010_0101_1011_0010_0 (parity 0) across 17 sda_clk periods of 4 clk each; out_valid high 68 cycles.
- Pause/resume: send 5 bits of the same words, cs=0 for 10 cycles, send the remaining 3 -> no err; identical frame to the basic case.
- Timeout: 5 bits, then cs=0 for 16 cycles -> err pulse on the 16th gap cycle, no ack. Then a fresh 8-bit collection of address 0x0F, data 0x0F (all bits LSB-first 1,1,1,1,0,0,0,0) -> frame 0000_1111_0000_1111_0.
- Busy masking: toggle cs/address/data during SHIFT -> frame unchanged, no extra ack; next frame only after out_valid falls.
- Reset mid-SHIFT: rst=1 for 1 cycle at frame bit 6 -> all outputs 0 next cycle, state IDLE; a following full collection produces a correct frame.
- Parameter sweep: ADDR_W=4, DATA_W=12, CLK_DIV=1, PARITY_EN=0, address 0x9, data 0xA5C -> L=12 collection cycles, address bits 4..11 ignored; sda 1001_1010_0101_1100, 16 bits x 2 cycles.
